tlv_dac_sched: RTL and testbench

TLV_DAC_SCHED -- requirements
Module: tlv_dac_sched

---
 rtl/tlv_dac_sched.sv | 162 ++++++++++++++++
 tb/tb_tlv_dac_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlv_dac_sched.sv
// Two-channel sample scheduler feeding a serial DAC writer, with round-robin arbitration and a writer timeout.
// Build option: define DAC_REF_INIT_EN to send a REF_WORD reference-setup frame after every rst.
module tlv_dac_sched #(
    parameter int          TIMEOUT  = 4095,
    parameter logic [15:0] REF_WORD = 16'hD002
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [11:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [11:0] b_data,
    output logic        b_ready,
    output logic [15:0] wr_word,
    output logic        wr_start,
    input  logic        wr_busy,
    output logic        busy,
    output logic        last_ch,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

`ifdef DAC_REF_INIT_EN
    typedef enum logic [2:0] {
        INIT      = 3'd0,
        ARB       = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;
    localparam state_t RESET_STATE = INIT;
`else
    typedef enum logic [2:0] {
        ARB       = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;
    localparam state_t RESET_STATE = ARB;
    logic [15:0] unused_ref_word_s;
    assign unused_ref_word_s = REF_WORD;
`endif

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [15:0]   wr_word_r;
    logic          wr_start_r;
    logic          last_ch_r;
    logic          timeout_err_r;
    logic          grant_a_s;
    logic          grant_b_s;

    // Counter saturates at TIMEOUT so a stuck writer can never wrap it.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CW'(1);
        end
    endfunction

    // Round-robin grant: a lone valid channel wins, a tie goes to the channel not served last.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (state_r == ARB && !wr_busy) begin
            if (a_valid && b_valid) begin
                if (last_ch_r) begin
                    grant_b_s = 1'b1;
                end else begin
                    grant_a_s = 1'b1;
                end
            end else begin
                grant_a_s = a_valid;
                grant_b_s = b_valid;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign a_ready     = grant_a_s;
    assign b_ready     = grant_b_s;
    assign wr_word     = wr_word_r;
    assign wr_start    = wr_start_r;
    assign busy        = (state_r != ARB);
    assign last_ch     = last_ch_r;
    assign timeout_err = timeout_err_r;

    // Scheduler FSM; cnt_r counts cycles since the wr_start pulse was raised.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_r       <= RESET_STATE;
            cnt_r         <= '0;
            wr_word_r     <= 16'h0000;
            wr_start_r    <= 1'b0;
            last_ch_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            wr_start_r <= 1'b0;
            case (state_r)
`ifdef DAC_REF_INIT_EN
                INIT: begin
                    wr_word_r  <= REF_WORD;
                    wr_start_r <= 1'b1;
                    cnt_r      <= '0;
                    state_r    <= ISSUE;
                end
`endif
                ARB: begin
                    if (grant_a_s) begin
                        wr_word_r  <= {4'hC, a_data};
                        last_ch_r  <= 1'b1;
                        wr_start_r <= 1'b1;
                        cnt_r      <= '0;
                        state_r    <= ISSUE;
                    end else if (grant_b_s) begin
                        wr_word_r  <= {4'h4, b_data};
                        last_ch_r  <= 1'b0;
                        wr_start_r <= 1'b1;
                        cnt_r      <= '0;
                        state_r    <= ISSUE;
                    end else begin
                        state_r <= ARB;
                    end
                end
                ISSUE: begin
                    cnt_r   <= sat_inc(cnt_r);
                    state_r <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (wr_busy) begin
                        state_r <= WAIT_DONE;
                    end else if (cnt_r >= CNT_LAST) begin
                        // Writer never accepted: drop the frame and keep the error sticky.
                        cnt_r         <= sat_inc(cnt_r);
                        timeout_err_r <= 1'b1;
                        state_r       <= ARB;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                WAIT_DONE: begin
                    if (!wr_busy) begin
                        state_r <= ARB;
                    end else begin
                        state_r <= WAIT_DONE;
                    end
                end
                default: begin
                    state_r <= RESET_STATE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlv_dac_sched.sv
// Directed bench for tlv_dac_sched with a small serial-writer model; TIMEOUT is set to 16.
module tb_tlv_dac_sched;

    logic        clk_50;
    logic        rst;
    logic        a_valid, b_valid;
    logic [11:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic [15:0] wr_word;
    logic        wr_start;
    logic        wr_busy;
    logic        busy;
    logic        last_ch;
    logic        timeout_err;

    logic        wr_busy_m;
    logic        busy_force;
    logic        ack_en;
    int          ack_dly;
    int          busy_len;
    logic [15:0] frames[$];
    int          n_pass;
    int          n_chk;
    int          base;
    logic        bad;

`ifdef DAC_REF_INIT_EN
    localparam logic INIT_BUSY   = 1'b1;
    localparam int   INIT_FRAMES = 1;
`else
    localparam logic INIT_BUSY   = 1'b0;
    localparam int   INIT_FRAMES = 0;
`endif

    assign wr_busy = wr_busy_m | busy_force;

    tlv_dac_sched #(.TIMEOUT(16), .REF_WORD(16'hD002)) dut (
        .clk_50(clk_50), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .wr_word(wr_word), .wr_start(wr_start), .wr_busy(wr_busy),
        .busy(busy), .last_ch(last_ch), .timeout_err(timeout_err)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    // Writer model: after a wr_start it raises wr_busy after ack_dly cycles for busy_len cycles.
    initial begin
        wr_busy_m = 1'b0;
        forever begin
            @(negedge clk_50);
            if (wr_start && ack_en) begin
                repeat (ack_dly) @(negedge clk_50);
                wr_busy_m = 1'b1;
                repeat (busy_len) @(negedge clk_50);
                wr_busy_m = 1'b0;
            end
        end
    end

    // Frame log: every word presented with a wr_start pulse.
    initial begin
        forever begin
            @(negedge clk_50);
            if (wr_start) frames.push_back(wr_word);
        end
    end

    task automatic cyc();
        @(negedge clk_50);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return a_ready;
            1:       return b_ready;
            default: return !busy;
        endcase
    endfunction

    // Bounded wait for a_ready (0), b_ready (1) or idle (2); an expired bound is a failed check.
    task automatic wait_for(input int which, input string tag);
        #1;
        for (int i = 0; i < 400; i++) begin
            if (probe(which)) break;
            cyc();
        end
        chk(tag, {31'd0, probe(which)}, 32'd1);
    endtask

    function automatic logic [15:0] frame_at(input int i);
        if (i < frames.size()) return frames[i];
        else return 16'hxxxx;
    endfunction

    // With the reference-setup option, the first frame after rst is REF_WORD and no ready is given meanwhile.
    task automatic post_reset();
`ifdef DAC_REF_INIT_EN
        base = frames.size();
        busy_len = 40;
        a_data = 12'h111;
        a_valid = 1'b1;
        bad = 1'b0;
        cyc();
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            if (a_ready || b_ready) bad = 1'b1;
            cyc();
        end
        a_valid = 1'b0;
        chk("init_idle", {31'd0, busy}, 32'd0);
        chk("init_no_ready", {31'd0, bad}, 32'd0);
        chk("init_ref_word", {16'd0, frame_at(base)}, 32'h0000D002);
        busy_len = 5;
`else
        cyc();
        chk("arb_after_rst", {31'd0, busy}, 32'd0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass = 0; n_chk = 0;
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_data = 12'h000; b_data = 12'h000;
        busy_force = 1'b0; ack_en = 1'b1; ack_dly = 1; busy_len = 5;
        repeat (3) cyc();
        chk("rst_wr_start", {31'd0, wr_start}, 32'd0);
        chk("rst_wr_word", {16'd0, wr_word}, 32'h0);
        chk("rst_last_ch", {31'd0, last_ch}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, {31'd0, INIT_BUSY});
        rst = 1'b0;
        post_reset();

        // Single channel A sample.
        a_data = 12'h123; a_valid = 1'b1;
        wait_for(0, "a_ready_single");
        chk("b_ready_single", {31'd0, b_ready}, 32'd0);
        cyc();
        chk("start_single", {31'd0, wr_start}, 32'd1);
        chk("word_single", {16'd0, wr_word}, 32'h0000C123);
        chk("last_ch_single", {31'd0, last_ch}, 32'd1);
        chk("busy_single", {31'd0, busy}, 32'd1);
        a_valid = 1'b0;
        cyc();
        chk("start_pulse_width", {31'd0, wr_start}, 32'd0);
        wait_for(2, "idle_single");
        chk("word_stable", {16'd0, wr_word}, 32'h0000C123);

        // Both channels valid: alternate starting with A after rst.
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        post_reset();
        base = frames.size();
        a_data = 12'h0AA; b_data = 12'h055; a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (frames.size() >= base + 4) break;
            cyc();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("rr_frame0", {16'd0, frame_at(base)}, 32'h0000C0AA);
        chk("rr_frame1", {16'd0, frame_at(base + 1)}, 32'h00004055);
        chk("rr_frame2", {16'd0, frame_at(base + 2)}, 32'h0000C0AA);
        chk("rr_frame3", {16'd0, frame_at(base + 3)}, 32'h00004055);
        wait_for(2, "idle_rr");

        // Writer never answers: sticky timeout 16 cycles after wr_start, then back to ARB.
        ack_en = 1'b0;
        a_data = 12'h321; a_valid = 1'b1;
        wait_for(0, "a_ready_to");
        cyc();
        chk("start_to", {31'd0, wr_start}, 32'd1);
        a_valid = 1'b0;
        repeat (15) cyc();
        chk("to_not_yet", {31'd0, timeout_err}, 32'd0);
        chk("to_waiting", {31'd0, busy}, 32'd1);
        cyc();
        chk("to_set", {31'd0, timeout_err}, 32'd1);
        chk("to_back_arb", {31'd0, busy}, 32'd0);
        ack_en = 1'b1;
        b_data = 12'h777; b_valid = 1'b1;
        wait_for(1, "b_ready_after_to");
        cyc();
        chk("word_after_to", {16'd0, wr_word}, 32'h00004777);
        chk("start_after_to", {31'd0, wr_start}, 32'd1);
        chk("last_ch_b", {31'd0, last_ch}, 32'd0);
        chk("to_sticky", {31'd0, timeout_err}, 32'd1);
        b_valid = 1'b0;
        wait_for(2, "idle_after_to");

        // Valid withdrawn while the writer is busy: nothing transfers.
        base = frames.size();
        busy_force = 1'b1; a_data = 12'h0F0; a_valid = 1'b1;
        cyc();
        chk("no_ready_wr_busy", {31'd0, a_ready}, 32'd0);
        a_valid = 1'b0; busy_force = 1'b0;
        cyc(); cyc();
        chk("withdraw_last_ch", {31'd0, last_ch}, 32'd0);
        chk("withdraw_idle", {31'd0, busy}, 32'd0);
        chk("withdraw_no_frame", frames.size(), base);

        // rst during WAIT_DONE abandons the frame.
        busy_len = 20;
        a_data = 12'h5A5; a_valid = 1'b1;
        wait_for(0, "a_ready_mid");
        cyc();
        chk("start_mid", {31'd0, wr_start}, 32'd1);
        a_valid = 1'b0;
        repeat (4) cyc();
        chk("in_wait_done", {31'd0, busy}, 32'd1);
        base = frames.size();
        rst = 1'b1;
        cyc();
        chk("mid_rst_wr_start", {31'd0, wr_start}, 32'd0);
        chk("mid_rst_wr_word", {16'd0, wr_word}, 32'h0);
        chk("mid_rst_last_ch", {31'd0, last_ch}, 32'd0);
        chk("mid_rst_err", {31'd0, timeout_err}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, {31'd0, INIT_BUSY});
        rst = 1'b0;
        repeat (30) cyc();
        chk("mid_rst_frames", frames.size(), base + INIT_FRAMES);
        chk("mid_rst_idle", {31'd0, busy}, 32'd0);
        busy_len = 5;
        a_data = 12'h001; b_data = 12'h002; a_valid = 1'b1; b_valid = 1'b1;
        wait_for(0, "restart_a_first");
        chk("restart_b_wait", {31'd0, b_ready}, 32'd0);
        cyc();
        chk("restart_word", {16'd0, wr_word}, 32'h0000C001);
        a_valid = 1'b0; b_valid = 1'b0;
        wait_for(2, "idle_end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
